// File: rtl/topk_pkg.sv
// topk_pkg: constants shared by the top-k input packer and the bitonic sorter stages.
//   FP32_POS_INF / FP32_NEG_INF : fp32 infinities used as pad words
//   topk_pad(ascending)         : pad word that sorts to the tail for the given direction
package topk_pkg;

    localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;

    function automatic logic [31:0] topk_pad(input logic ascending);
        return ascending ? FP32_POS_INF : FP32_NEG_INF;
    endfunction

endpackage

// File: rtl/topk_input_packer.sv
// topk_input_packer: packs a scalar fp32 stream into 2**LOG_INPUT_NUM-lane vectors for the
// bitonic sorter. Frames closed early by s_last are padded with an infinity that sorts last.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   s_valid/s_ready/s_data     scalar input stream
//   s_last                     input word closes the current frame
//   o_valid/o_ready            output vector handshake
//   y                          packed vector, lane i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   o_count                    number of real (non-pad) lanes, 1..N
//   o_last                     vector was closed by s_last
module topk_input_packer
    import topk_pkg::*;
#(
    parameter int unsigned LOG_INPUT_NUM = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          ASCENDING     = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      s_valid,
    input  logic [DATA_WIDTH-1:0]                     s_data,
    input  logic                                      s_last,
    output logic                                      s_ready,
    output logic                                      o_valid,
    input  logic                                      o_ready,
    output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  y,
    output logic [LOG_INPUT_NUM:0]                    o_count,
    output logic                                      o_last
);

    localparam int unsigned N = 2 ** LOG_INPUT_NUM;
    localparam logic [DATA_WIDTH-1:0] Pad = DATA_WIDTH'(topk_pad(ASCENDING));

    // Assembly register and its bookkeeping
    logic [DATA_WIDTH-1:0]    a_q [N];
    logic [DATA_WIDTH-1:0]    a_d [N];
    logic [LOG_INPUT_NUM-1:0] c_q, c_d;
    logic                     a_full_q, a_full_d;
    logic [LOG_INPUT_NUM:0]   a_cnt_q, a_cnt_d;
    logic                     a_last_q, a_last_d;

    // Output register
    logic [DATA_WIDTH-1:0]    y_q [N];
    logic                     o_valid_q;
    logic [LOG_INPUT_NUM:0]   o_count_q;
    logic                     o_last_q;

    logic [DATA_WIDTH-1:0]    merged [N];
    logic [N-1:0]             lane_we;

    logic y_free;
    logic accept;
    logic complete;
    logic load_y_from_a;
    logic load_y_direct;
    logic store_a;
    logic [LOG_INPUT_NUM:0] c_plus1;

    always_comb begin
        y_free        = !o_valid_q | o_ready;
        s_ready       = !rst & (!a_full_q | y_free);
        accept        = s_valid & s_ready;
        complete      = accept & ((&c_q) | s_last);
        load_y_from_a = a_full_q & y_free;
        // A pending A vector has priority on Y; a completing word that cycle goes to A instead.
        load_y_direct = complete & !a_full_q & y_free;
        store_a       = complete & !load_y_direct;
        c_plus1       = {1'b0, c_q} + 1'b1;
    end

    // Per-lane write-enable decode and pad mask. c_q is always 0 while a_full_q is set, so
    // an accept alongside the A->Y transfer naturally starts a fresh vector at lane 0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [LOG_INPUT_NUM-1:0] Idx = LOG_INPUT_NUM'(i);

        assign lane_we[i] = accept & (c_q == Idx);
        assign merged[i]  = (Idx < c_q)  ? a_q[i] :
                            (Idx == c_q) ? s_data : Pad;
        assign a_d[i]     = store_a    ? merged[i] :
                            lane_we[i] ? s_data    : a_q[i];
        assign y[DATA_WIDTH*i +: DATA_WIDTH] = y_q[i];
    end

    always_comb begin
        c_d      = c_q;
        a_full_d = a_full_q;
        a_cnt_d  = a_cnt_q;
        a_last_d = a_last_q;
        if (complete) begin
            c_d = '0;
        end else if (accept) begin
            c_d = c_q + 1'b1;
        end
        if (store_a) begin
            a_full_d = 1'b1;
            a_cnt_d  = c_plus1;
            a_last_d = s_last;
        end else if (load_y_from_a) begin
            a_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                y_q[i] <= '0;
            end
            c_q       <= '0;
            a_full_q  <= 1'b0;
            a_cnt_q   <= '0;
            a_last_q  <= 1'b0;
            o_valid_q <= 1'b0;
            o_count_q <= '0;
            o_last_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            c_q      <= c_d;
            a_full_q <= a_full_d;
            a_cnt_q  <= a_cnt_d;
            a_last_q <= a_last_d;
            if (load_y_from_a) begin
                y_q       <= a_q;
                o_count_q <= a_cnt_q;
                o_last_q  <= a_last_q;
                o_valid_q <= 1'b1;
            end else if (load_y_direct) begin
                y_q       <= merged;
                o_count_q <= c_plus1;
                o_last_q  <= s_last;
                o_valid_q <= 1'b1;
            end else if (o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_count = o_count_q;
    assign o_last  = o_last_q;

endmodule

// File: tb/tb_topk_input_packer.sv
module tb_topk_input_packer;

    localparam int N = 4;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] NINF = 32'hFF800000;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [31:0]  s_data;
    logic         s_last;
    logic         o_ready;
    logic         s_ready, o_valid, o_last;
    logic [127:0] y;
    logic [2:0]   o_count;
    logic         s_ready_n, o_valid_n, o_last_n;
    logic [127:0] y_n;
    logic [2:0]   o_count_n;

    always #5 clk = ~clk;

    topk_input_packer #(.LOG_INPUT_NUM(2), .DATA_WIDTH(32), .ASCENDING(1'b1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .o_valid(o_valid), .o_ready(o_ready), .y(y),
        .o_count(o_count), .o_last(o_last)
    );

    topk_input_packer #(.LOG_INPUT_NUM(2), .DATA_WIDTH(32), .ASCENDING(1'b0)) dut_n (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready_n), .o_valid(o_valid_n), .o_ready(o_ready), .y(y_n),
        .o_count(o_count_n), .o_last(o_last_n)
    );

    typedef struct packed {
        logic [127:0] y;
        logic [2:0]   cnt;
        logic         last;
    } vec_t;

    vec_t        exp_p[$];
    vec_t        exp_n[$];
    int          total = 0;
    int          bad = 0;
    int          n_out = 0;
    logic [31:0] m_lanes [N];
    int          m_c = 0;
    logic [31:0] w [12];

    // Frame model: builds expected vectors for both pad directions as words are accepted.
    task automatic model_accept(input logic [31:0] d, input logic last);
        vec_t vp, vn;
        m_lanes[m_c] = d;
        if (m_c == N - 1 || last) begin
            for (int i = 0; i < N; i++) begin
                vp.y[32*i +: 32] = (i <= m_c) ? m_lanes[i] : PINF;
                vn.y[32*i +: 32] = (i <= m_c) ? m_lanes[i] : NINF;
            end
            vp.cnt = 3'(m_c + 1);
            vp.last = last;
            vn.cnt = vp.cnt;
            vn.last = last;
            exp_p.push_back(vp);
            exp_n.push_back(vn);
            m_c = 0;
        end else begin
            m_c++;
        end
    endtask

    // Inputs change 1 time unit after posedge; s_ready is sampled at negedge.
    task automatic send_word(input logic [31:0] d, input logic last, output int waited);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        waited  = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                @(posedge clk);
                #1;
                model_accept(d, last);
                done = 1;
            end else begin
                waited++;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %h not accepted within 40 cycles", d);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop and compare whenever a handshake will happen at the next posedge.
    always @(negedge clk) begin
        vec_t e;
        if (rst === 1'b0 && o_valid === 1'b1 && o_ready === 1'b1) begin
            total++;
            n_out++;
            if (exp_p.size() == 0) begin
                bad++;
                $display("FAIL unexpected_vec_pos: got y=%h cnt=%0d last=%0d, none expected",
                         y, o_count, o_last);
            end else begin
                e = exp_p.pop_front();
                if ({y, o_count, o_last} !== e) begin
                    bad++;
                    $display("FAIL vec_pos: got y=%h cnt=%0d last=%0d, want y=%h cnt=%0d last=%0d",
                             y, o_count, o_last, e.y, e.cnt, e.last);
                end
            end
        end
        if (rst === 1'b0 && o_valid_n === 1'b1 && o_ready === 1'b1) begin
            total++;
            if (exp_n.size() == 0) begin
                bad++;
                $display("FAIL unexpected_vec_neg: got y=%h cnt=%0d last=%0d, none expected",
                         y_n, o_count_n, o_last_n);
            end else begin
                e = exp_n.pop_front();
                if ({y_n, o_count_n, o_last_n} !== e) begin
                    bad++;
                    $display("FAIL vec_neg: got y=%h cnt=%0d last=%0d, want y=%h cnt=%0d last=%0d",
                             y_n, o_count_n, o_last_n, e.y, e.cnt, e.last);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        o_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 5;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
        if (y !== '0) begin bad++; $display("FAIL rst_y: got %h want 0", y); end
        if (o_count !== 3'd0) begin bad++; $display("FAIL rst_o_count: got %0d want 0", o_count); end
        if (o_last !== 1'b0) begin bad++; $display("FAIL rst_o_last: got %b want 0", o_last); end
        if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_s_ready: got %b want 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_vector();
        int wt, stalls = 0, n0 = n_out;
        for (int i = 0; i < 4; i++) begin
            send_word(w[i], 1'b0, wt);
            stalls += wt;
        end
        @(negedge clk);
        total++;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL latency_o_valid: got %b want 1", o_valid); end
        @(posedge clk);
        #1;
        // Second frame back to back, checks no bubble at the vector boundary.
        for (int i = 4; i < 12; i++) begin
            send_word(w[i], 1'b0, wt);
            stalls += wt;
        end
        idle(4);
        total += 3;
        if (stalls !== 0) begin bad++; $display("FAIL full_stalls: got %0d want 0", stalls); end
        if (n_out - n0 !== 3) begin bad++; $display("FAIL full_count: got %0d want 3", n_out - n0); end
        if (exp_p.size() !== 0) begin bad++; $display("FAIL full_left: got %0d want 0", exp_p.size()); end
    endtask

    task automatic test_pad();
        int wt, n0 = n_out;
        send_word(32'h40A00000, 1'b0, wt);
        send_word(32'h40C00000, 1'b1, wt);
        idle(4);
        total += 2;
        if (n_out - n0 !== 1) begin bad++; $display("FAIL pad_count: got %0d want 1", n_out - n0); end
        if (exp_n.size() !== 0) begin bad++; $display("FAIL pad_left: got %0d want 0", exp_n.size()); end
    endtask

    task automatic test_backpressure();
        int wt, stalls = 0, n0 = n_out;
        logic [127:0] first_vec;
        first_vec = {w[3], w[2], w[1], w[0]};
        o_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_word(w[i], 1'b0, wt);
            stalls += wt;
        end
        total++;
        if (stalls !== 0) begin bad++; $display("FAIL bp_fill_stalls: got %0d want 0", stalls); end
        s_valid = 1'b1;
        s_data  = w[8];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total += 3;
            if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
            if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_o_valid: got %b want 1", o_valid); end
            if (y !== first_vec) begin bad++; $display("FAIL bp_hold_y: got %h want %h", y, first_vec); end
            @(posedge clk);
            #1;
        end
        o_ready = 1'b1;
        for (int i = 8; i < 12; i++) send_word(w[i], 1'b0, wt);
        idle(5);
        total += 2;
        if (n_out - n0 !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", n_out - n0); end
        if (exp_p.size() !== 0) begin bad++; $display("FAIL bp_left: got %0d want 0", exp_p.size()); end
    endtask

    task automatic test_last_lane3();
        int wt, n0 = n_out;
        for (int i = 0; i < 4; i++) send_word(w[i + 4], i == 3, wt);
        send_word(w[10], 1'b0, wt);
        send_word(w[11], 1'b1, wt);
        idle(4);
        total++;
        if (n_out - n0 !== 2) begin bad++; $display("FAIL last3_count: got %0d want 2", n_out - n0); end
    endtask

    task automatic test_single();
        int wt, n0 = n_out;
        send_word(32'h40E00000, 1'b1, wt);
        idle(4);
        total++;
        if (n_out - n0 !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", n_out - n0); end
    endtask

    task automatic test_reset_mid_frame();
        int wt, n0;
        send_word(w[0], 1'b0, wt);
        send_word(w[1], 1'b0, wt);
        rst = 1'b1;
        m_c = 0;
        exp_p.delete();
        exp_n.delete();
        @(negedge clk);
        total += 4;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_o_valid: got %b want 0", o_valid); end
        if (y !== '0) begin bad++; $display("FAIL mid_rst_y: got %h want 0", y); end
        if (o_count !== 3'd0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", o_count); end
        if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_s_ready: got %b want 0", s_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n0 = n_out;
        for (int i = 8; i < 12; i++) send_word(w[i], 1'b0, wt);
        idle(4);
        total += 2;
        if (n_out - n0 !== 1) begin bad++; $display("FAIL mid_rst_count: got %0d want 1", n_out - n0); end
        if (exp_p.size() !== 0) begin bad++; $display("FAIL mid_rst_left: got %0d want 0", exp_p.size()); end
    endtask

    initial begin
        w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
        test_reset();
        test_full_vector();
        test_pad();
        test_backpressure();
        test_last_lane3();
        test_single();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/topk_input_packer.md
# topk_input_packer

Upstream front end of the bitonic sorting network. It accepts a scalar fp32 stream with valid/ready and a `s_last` frame marker, and packs consecutive words into one `2**LOG_INPUT_NUM`-lane vector. Partial vectors closed by `s_last` are padded with a sentinel that sorts to the tail of the output order. Finished vectors are presented with valid/ready; `o_valid & o_ready` drives the sorter's `i_valid` and `y` drives its `x`.

## Interface
- `LOG_INPUT_NUM`, 4: vector has N = 2**LOG_INPUT_NUM lanes; must be ≥ 1.
- `DATA_WIDTH`, 32: lane width; fixed at 32 (fp32).
- `ASCENDING`, 1: must match the downstream sorter. Selects the pad value: 1 → +inf `0x7F800000`; 0 → −inf `0xFF800000`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `s_valid` input 1: input word valid.
- `s_data` input DATA_WIDTH: input word.
- `s_last` input 1: this word ends the frame.
- `s_ready` output 1: word accepted when `s_valid & s_ready`.
- `o_valid` output 1: vector `y` valid.
- `o_ready` input 1: downstream accepts the vector.
- `y` output DATA_WIDTH*N: packed vector, lane i at bits `[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]`.
- `o_count` output LOG_INPUT_NUM+1: number of real (non-pad) lanes, 1..N.
- `o_last` output 1: vector closed by `s_last`.

## Operation
State:
- Assembly register `A` (N lanes).
- Fill counter `c`, 0..N−1.
- Flag `a_full`: `A` holds a completed vector.
- Output register `Y` with `o_valid`, `o_count`, `o_last`.

Rules:
- Define `y_free = !o_valid | o_ready`.
- `s_ready = !rst & (!a_full | y_free)`.
- An accepted word is written to lane `c`. It completes the vector when `c == N−1` or `s_last == 1`.
- Non-completing accept: `A[c] <= s_data`, `c <= c+1`.
- Completing accept while `!a_full`:
  - Form the merged vector: lanes < c from `A`, lane c = `s_data`, lanes > c = PAD.
  - Set count = c+1, last = `s_last`.
  - If `y_free`, load the merged vector into `Y` directly. Otherwise load it into `A` and set `a_full`.
  - In both cases `c <= 0`.
- `a_full & y_free`:
  - `Y <= A` with its stored count and last, and clear `a_full`.
  - An accept in the same cycle writes into a fresh `A` at lane 0, handled by the rules above with `a_full` treated as 0. That accept cannot load `Y`.
- A vector is never emitted empty.
- `s_last` on lane N−1 gives a full vector with `o_count = N`, `o_last = 1`.
- Padding is applied only to lanes ≥ count. Lanes < count are always real data.
- `Y`, `o_count`, and `o_last` are held stable while `o_valid & !o_ready`.
- `o_valid` clears on handshake unless a new vector loads the same cycle.
- Word order is preserved: lane index equals arrival order within the vector.

## Timing
- Reset values: `o_valid=0`, `y=0`, `o_count=0`, `o_last=0`, `c=0`, `a_full=0`, `A=0`. `s_ready=0` while `rst` is high, and 1 in the first cycle after release.
- Reset mid-frame drops the partial vector and any pending `A` or `Y` with no output.
- Latency: a completing word accepted at edge t gives `o_valid=1` after edge t (visible in cycle t+1) when `y_free` held in cycle t.
- Throughput: one word per cycle sustained while `o_ready=1`. No bubble at vector boundaries.
- Backpressure: `o_ready=0` allows one more complete vector to build in `A`. `s_ready` then drops in the cycle after `A` completes. It rises combinationally in any cycle where `o_ready=1`.
- Combinational paths: only `o_ready → s_ready`. `y` and `o_*` are registered.

## Structure
- Shared package `topk_pkg`:
  - `FP32_POS_INF = 32'h7F800000`
  - `FP32_NEG_INF = 32'hFF800000`
  - function `topk_pad(ascending)` returning the pad word
- The sorter stages import the same constants.
- No sub-module: lane write-enable decode and pad mask are a generate loop over N lanes within this module.

## Test plan
N = 4 (LOG_INPUT_NUM=2), ASCENDING=1, `o_ready=1`, unless stated.
- Words 1.0, 2.0, 3.0, 4.0 on consecutive cycles, no `s_last` → one `o_valid` cycle, lanes 0..3 = 1,2,3,4, `o_count=4`, `o_last=0`, `s_ready` never low.
- 5.0, 6.0 with `s_last` on 6.0 → lanes = 5, 6, +inf, +inf, `o_count=2`, `o_last=1`. Repeat with ASCENDING=0 → pads `0xFF800000`.
- `o_ready=0`, stream 12 words → `Y` holds words 1–4, `A` fills with 5–8, `s_ready` drops after word 8. Raise `o_ready` → vectors emitted in order, words 9–12 form the third vector, no loss or duplication.
- `s_last` on lane 3 → `o_count=4`, `o_last=1`, no pad lanes. Next frame restarts at lane 0.
- Single word 7.0 with `s_last` → lanes 7, +inf, +inf, +inf, `o_count=1`.
- Assert `rst` after 2 words of a frame, release, send 4 words → only the post-reset vector appears. All outputs are 0 during reset.
